imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory consumed by the fetch stage. It receives a framed byte stream over a valid/ready interface, assembles little-endian 32-bit words, and drives a one-word-per-cycle write port into instruction memory. It holds the core in reset through its `core_rst_n` output until a complete, valid image has been committed.

---
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses A5-framed byte stream, writes LE words, holds core in reset.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LEN_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_error,
  output logic [10:0] words_loaded
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        asm_q, asm_d;
  logic [10:0]        words_q, words_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               ready_q;
  logic               crn_q, crn_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               accept;
  logic [LEN_W-1:0]   len_full;
  logic [LEN_W-1:0]   words_next;
  logic               last_word;

  assign accept     = in_valid && ready_q;
  // The length field is fixed at two bytes, so LEN_W must stay 16.
  assign len_full   = {in_data, len_q[7:0]};
  assign words_next = LEN_W'(words_q) + LEN_W'(1);
  assign last_word  = (words_next == len_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    crn_d      = crn_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept && in_data == SYNC) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0 || len_full > LEN_W'(DEPTH_WORDS)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            crn_d   = 1'b0;
            done_d  = 1'b0;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
            words_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = 8'h00;
`endif
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = 32'({words_q, 2'b00});
              wdata_d = {in_data, asm_q};
              words_d = words_q + 11'd1;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                // Status rises one cycle later, after the final write has committed.
                state_d = S_DONE;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            crn_d   = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        done_d = 1'b1;
        crn_d  = 1'b1;
        if (accept && in_data == SYNC) begin
          state_d = S_LEN0;
          done_d  = 1'b0;
          crn_d   = 1'b0;
        end
      end
      S_ERROR: begin
        if (accept && in_data == SYNC) begin
          state_d = S_LEN0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      crn_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= 1'b1;
      crn_q      <= crn_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready     = ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_rst_n   = crn_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-position reference model compared every cycle,
// plus literal expectations for the directed scenarios. Honours IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, core_rst_n, load_done, load_error;
  logic [31:0] imem_addr, imem_wdata;
  logic [10:0] words_loaded;

  imem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks position within the current frame and derives outputs from it.
  logic        exp_ready = 1'b0, exp_we = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_crn = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, word_buf = '0;
  int          exp_words = 0, pos = 0, m_len = 0, m_k = 0;
  logic [7:0]  len_lo = '0, csum = '0, m_b = '0;
  bit          pending_done = 1'b0, m_acc = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_ready = 0; exp_we = 0; exp_done = 0; exp_err = 0; exp_crn = 0;
      exp_addr = 0; exp_wdata = 0; exp_words = 0; pos = 0; pending_done = 0;
    end else begin
      m_acc = in_valid && exp_ready;
      m_b   = in_data;
      exp_ready = 1;
      exp_we    = 0;
      if (pending_done) begin
        exp_done = 1; exp_crn = 1; pending_done = 0;
      end
      if (m_acc) begin
        if (pos == 0) begin
          if (m_b == 8'hA5) begin
            pos = 1; exp_done = 0; exp_crn = 0; exp_err = 0;
          end
        end else if (pos == 1) begin
          len_lo = m_b; pos = 2;
        end else if (pos == 2) begin
          m_len = int'({m_b, len_lo});
          if (m_len == 0 || m_len > DEPTH) begin
            exp_err = 1; pos = 0;
          end else begin
            exp_words = 0; csum = 0; pos = 3;
          end
        end else if (pos < 3 + 4 * m_len) begin
          m_k = pos - 3;
          word_buf[8*(m_k%4) +: 8] = m_b;
          csum = csum ^ m_b;
          pos++;
          if (m_k % 4 == 3) begin
            exp_we    = 1;
            exp_addr  = 32'((m_k / 4) * 4);
            exp_wdata = word_buf;
            exp_words = m_k / 4 + 1;
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (exp_words == m_len) begin
              pending_done = 1; pos = 0;
            end
`endif
          end
        end else begin
          if (m_b == csum) begin
            exp_done = 1; exp_crn = 1;
          end else begin
            exp_err = 1;
          end
          pos = 0;
        end
      end
    end
  end

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("imem_we", 32'(imem_we), 32'(exp_we));
    check("imem_addr", imem_addr, exp_addr);
    check("imem_wdata", imem_wdata, exp_wdata);
    check("core_rst_n", 32'(core_rst_n), 32'(exp_crn));
    check("load_done", 32'(load_done), 32'(exp_done));
    check("load_error", 32'(load_error), 32'(exp_err));
    check("words_loaded", 32'(words_loaded), 32'(exp_words));
    if (imem_we === 1'b1) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int budget;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    while (!in_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  logic [31:0] frame_q[$];

  task automatic send_frame(input bit bad_chk, input bit gaps, input bit with_sync);
    logic [7:0] cs;
    int n;
    cs = 8'h00;
    n  = frame_q.size();
    if (with_sync) send_byte(8'hA5, gaps);
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    foreach (frame_q[i]) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] by;
        by = frame_q[i][8*j +: 8];
        cs = cs ^ by;
        send_byte(by, gaps);
      end
    end
    if (bad_chk) cs = ~cs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, gaps);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] gb;
    // Reset values and ready timing
    tick(2);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    #2 rst = 1'b1;
    tick(1);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Basic load
    cap_addr.delete(); cap_data.delete();
    frame_q = '{32'h0000_0013, 32'h0010_0093};
    send_frame(1'b0, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("basic_done_after_chk", 32'(load_done), 32'd1);
`else
    check("basic_last_we", 32'(imem_we), 32'd1);
    check("basic_done_not_yet", 32'(load_done), 32'd0);
    tick(1);
    check("basic_done_next", 32'(load_done), 32'd1);
`endif
    tick(2);
    check("basic_nwrites", cap_addr.size(), 32'd2);
    if (cap_addr.size() == 2) begin
      check("basic_addr0", cap_addr[0], 32'h0);
      check("basic_data0", cap_data[0], 32'h0000_0013);
      check("basic_addr1", cap_addr[1], 32'h4);
      check("basic_data1", cap_data[1], 32'h0010_0093);
    end
    check("basic_words", 32'(words_loaded), 32'd2);
    check("basic_core_rst_n", 32'(core_rst_n), 32'd1);

    // Reload drops core reset the next cycle
    send_byte(8'hA5, 1'b0);
    check("reload_crn", 32'(core_rst_n), 32'd0);
    check("reload_done", 32'(load_done), 32'd0);
    frame_q = '{32'hDEAD_BEEF};
    send_frame(1'b0, 1'b0, 1'b0);
    tick(2);
    check("reload_done_again", 32'(load_done), 32'd1);

    // Sync hunting
    cap_addr.delete(); cap_data.delete();
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h3C, 1'b0);
    frame_q = '{32'h1234_5678};
    send_frame(1'b0, 1'b0, 1'b1);
    tick(2);
    check("hunt_nwrites", cap_addr.size(), 32'd1);
    if (cap_addr.size() == 1) check("hunt_addr", cap_addr[0], 32'h0);

    // Bad lengths
    cap_addr.delete(); cap_data.delete();
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check("len0_err", 32'(load_error), 32'd1);
    check("len0_crn", 32'(core_rst_n), 32'd0);
    send_byte(8'hA5, 1'b0);
    check("err_clear_on_sync", 32'(load_error), 32'd0);
    send_byte(8'h01, 1'b0); send_byte(8'h04, 1'b0);
    check("len1025_err", 32'(load_error), 32'd1);
    tick(2);
    check("badlen_nwrites", cap_addr.size(), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum then recovery
    cap_addr.delete(); cap_data.delete();
    frame_q = '{32'hCAFE_F00D};
    send_frame(1'b1, 1'b0, 1'b1);
    check("badchk_err", 32'(load_error), 32'd1);
    check("badchk_crn", 32'(core_rst_n), 32'd0);
    check("badchk_nwrites", cap_addr.size(), 32'd1);
    send_frame(1'b0, 1'b0, 1'b1);
    check("recover_err", 32'(load_error), 32'd0);
    check("recover_done", 32'(load_done), 32'd1);
`endif

    // Asynchronous reset halfway through a word
    cap_addr.delete(); cap_data.delete();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_ready", 32'(in_ready), 32'd0);
    check("async_done", 32'(load_done), 32'd0);
    check("async_err", 32'(load_error), 32'd0);
    check("async_addr", imem_addr, 32'h0);
    check("async_wdata", imem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick(2);
    check("async_nwrites", cap_addr.size(), 32'd0);

    // Randomized frames with garbage between them
    for (int f = 0; f < 10; f++) begin
      repeat ($urandom_range(0, 2)) begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        send_byte(gb, 1'b1);
      end
      if ($urandom_range(0, 5) == 0) begin
        send_byte(8'hA5, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
      end else begin
        frame_q.delete();
        repeat ($urandom_range(1, 6)) frame_q.push_back($urandom);
        send_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'b1);
      end
    end
    tick(2);

    // Maximum frame with valid gaps
    cap_addr.delete(); cap_data.delete();
    frame_q.delete();
    repeat (DEPTH) frame_q.push_back($urandom);
    send_frame(1'b0, 1'b1, 1'b1);
    tick(3);
    check("max_nwrites", cap_addr.size(), 32'(DEPTH));
    if (cap_addr.size() == DEPTH) check("max_last_addr", cap_addr[DEPTH-1], 32'hFFC);
    check("max_words", 32'(words_loaded), 32'd1024);
    check("max_done", 32'(load_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
